// File: rtl/cp0_exc_ctrl_if.sv
// Pipeline-facing bundle of the CP0 exception controller.
// The pipeline drives the M-stage side (master). The controller (slave) returns the
// trap request, the read data and the redirect targets.
interface cp0_exc_ctrl_if;
    logic [31:0] pc_m;
    logic [4:0]  exccode_m;
    logic        bd_m;
    logic [5:0]  hwint;
    logic [4:0]  cp0_addr;
    logic        cp0_we;
    logic [31:0] cp0_wdata;
    logic        eret_m;
    logic [31:0] cp0_rdata;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    modport master (
        output pc_m, exccode_m, bd_m, hwint, cp0_addr, cp0_we, cp0_wdata, eret_m,
        input  cp0_rdata, req, handler_pc, epc_out
    );

    modport slave (
        input  pc_m, exccode_m, bd_m, hwint, cp0_addr, cp0_we, cp0_wdata, eret_m,
        output cp0_rdata, req, handler_pc, epc_out
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller.
// Holds SR/Cause/EPC/PRId and decides combinationally whether the M-stage instruction
// traps. It also serves mfc0/mtc0 and sequences eret.
// SR.EXL doubles as the two-state NORMAL/IN_HANDLER state bit.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL     = 32'h1234_5678
) (
    input  logic           clk,
    input  logic           reset,
    cp0_exc_ctrl_if.slave  bus
);
    localparam logic [0:0] ST_NORMAL     = 1'b0;
    localparam logic [0:0] ST_IN_HANDLER = 1'b1;

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // Architectural state; EPC keeps only the word address
    logic [5:0]  im_q,      im_d;
    logic        ie_q,      ie_d;
    logic [0:0]  state_q,   state_d;
    logic [5:0]  ip_q,      ip_d;
    logic        bd_q,      bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [29:0] epc_q,     epc_d;

    logic        int_req;
    logic        exc_req;
    logic        trap;
    logic [29:0] epc_trap;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] rdata;

    // The PC byte offset never reaches EPC, which is always word-aligned
    logic        pc_lsb_unused;
    assign pc_lsb_unused = ^bus.pc_m[1:0];

    assign int_req = (|(bus.hwint & im_q)) & ie_q & (state_q == ST_NORMAL);
    assign exc_req = (bus.exccode_m != 5'd0) & (state_q == ST_NORMAL);
    // Gating with reset makes req drop at the same instant reset is applied
    assign trap    = (int_req | exc_req) & ~reset;

    // A delay-slot instruction resumes at its branch, one word back
    assign epc_trap = bus.bd_m ? (bus.pc_m[31:2] - 30'd1) : bus.pc_m[31:2];

    assign sr_word    = {16'b0, im_q, 8'b0, state_q, ie_q};
    assign cause_word = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};

    // Next-state selection: trap beats eret, and eret beats mtc0
    always_comb begin
        im_d      = im_q;
        ie_d      = ie_q;
        state_d   = state_q;
        ip_d      = bus.hwint;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (trap) begin
            state_d   = ST_IN_HANDLER;
            exccode_d = int_req ? 5'd0 : bus.exccode_m;
            bd_d      = bus.bd_m;
            epc_d     = epc_trap;
        end else if (bus.eret_m) begin
            state_d = ST_NORMAL;
        end else if (bus.cp0_we) begin
            case (bus.cp0_addr)
                ADDR_SR: begin
                    im_d    = bus.cp0_wdata[15:10];
                    state_d = bus.cp0_wdata[1];
                    ie_d    = bus.cp0_wdata[0];
                end
                ADDR_EPC: epc_d = bus.cp0_wdata[31:2];
                default:  ;
            endcase
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q      <= 6'd0;
            ie_q      <= 1'b0;
            state_q   <= ST_NORMAL;
            ip_q      <= 6'd0;
            bd_q      <= 1'b0;
            exccode_q <= 5'd0;
            epc_q     <= 30'd0;
        end else begin
            im_q      <= im_d;
            ie_q      <= ie_d;
            state_q   <= state_d;
            ip_q      <= ip_d;
            bd_q      <= bd_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    // mfc0 read port shows the pre-edge register contents
    always_comb begin
        rdata = 32'd0;
        case (bus.cp0_addr)
            ADDR_SR:    rdata = sr_word;
            ADDR_CAUSE: rdata = cause_word;
            ADDR_EPC:   rdata = {epc_q, 2'b00};
            ADDR_PRID:  rdata = PRID_VAL;
            default:    rdata = 32'd0;
        endcase
    end

    assign bus.cp0_rdata  = rdata;
    assign bus.req        = trap;
    assign bus.handler_pc = HANDLER_ADDR;
    assign bus.epc_out    = {epc_q, 2'b00};
endmodule
